rr_arb8_dec: RTL and testbench
==============================

// Module: rr_arb8_dec
// PURPOSE
//  Round-robin arbiter that shares one resource among 8 requesters.
//  Grants are one-hot and come from a registered 3-bit grant index fed
//  through a 3-to-8 decode.
//  Sits between 8 request sources and a single shared datapath/bus.
//  An optional hold limit stops one requester from keeping the resource.
// PARAMETERS
//  MAX_HOLD  16  max consecutive BUSY cycles per grant; 0 = unlimited
//  CNT_W     5   width of hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk      in   1  rising-edge clock, single clock domain
//  rst      in   1  synchronous reset, active-high
//  en       in   1  1 = new grants allowed; 0 = no new grant (active grant continues)
//  req      in   8  request bit per requester; holding it high = still using the resource
//  gnt      out  8  one-hot grant = decode of gnt_idx, gated by gnt_vld
//  gnt_idx  out  3  index of current/last granted requester
//  gnt_vld  out  1  1 while a grant is active
//  preempt  out  1  1-cycle pulse when the hold limit forces a release
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//   - gnt=0, gnt_vld=0, preempt=0, gnt_idx=3'd7
//   - state=IDLE, hold_cnt=0, ptr=3'd7 (so requester 0 has first priority)
//   - Reset mid-grant drops gnt on the next edge; nothing is retained.
//  FSM states: IDLE, BUSY.
//  IDLE, en=1, req!=0:
//   - pick first set req[i] searching ptr+1, ptr+2, ... (mod 8), ptr last
//   - next edge: gnt_idx=i, ptr=i, gnt_vld=1, hold_cnt=0, state=BUSY
//   - latency req->gnt = 1 clock
//  IDLE, en=0 or req==0: stay IDLE; gnt=0.
//  BUSY (i = gnt_idx):
//   - req[i]=0 at edge: next state IDLE, gnt_vld=0, preempt=0
//   - req[i]=1 and MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1:
//     next state IDLE, gnt_vld=0, preempt=1 for exactly one cycle
//   - otherwise: stay BUSY, hold_cnt+=1 (saturates, never wraps)
//   - changes on other req bits are ignored while BUSY
//   - en has no effect while BUSY
//  Every release is followed by >=1 IDLE cycle with gnt=0 (bus turnaround).
//  Minimum request-to-request spacing at the resource is therefore 2 clocks.
//  Fairness: a preempted requester that keeps req high is granted again
//   only after every other active requester (ptr already points at it).
//  ptr wraps 7->0 through modulo-8 arithmetic on 3 bits.
//  gnt is always one-hot or zero; never more than 1 bit set.
//  gnt_idx holds its last value in IDLE; only gnt_vld/gnt qualify it.
//  All outputs are registered; no combinational path from req to gnt.
// TESTING
//  1 Reset, req=8'h81, en=1 -> after 1 clk gnt=8'h01, gnt_idx=0; drop req[0]
//    -> gnt=0 for 1 clk, then gnt=8'h80
//  2 req=8'hFF held, MAX_HOLD=0, each holder drops req after 3 BUSY cycles
//    -> grant order 0,1,...,7,0 with one gap cycle between grants
//  3 MAX_HOLD=4, req=8'h04 held constant -> gnt=8'h04 for 4 clks, then
//    preempt=1 + gnt=0 for 1 clk, then re-grant 8'h04
//  4 MAX_HOLD=4, req=8'h14 held -> grant 2 (4 clks), preempt, grant 4,
//    preempt, grant 2: no requester starves
//  5 en=0 with req=8'h10 -> gnt stays 0; raise en -> gnt=8'h10 next clk;
//    drop en during BUSY -> grant kept
//  6 rst=1 during BUSY with gnt=8'h20 -> next clk gnt=0, gnt_idx=7;
//    req=8'h20 afterwards -> gnt=8'h20 one clk after rst deasserts

Source files
------------

// File: rtl/rr_arb8_dec.sv
// rr_arb8_dec: 8-way round-robin arbiter with a registered grant index,
// one-hot grant decode and an optional hold limit that forces a release.
module rr_arb8_dec #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       preempt
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Last BUSY count before a forced release; unused when MAX_HOLD is 0.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [2:0]       pick;
    logic [2:0]       cand;

    // Rotating priority search: ptr+1 first, ptr itself last. Scanning
    // downwards lets the nearest candidate overwrite the farther ones.
    always_comb begin
        pick = ptr;
        cand = ptr;
        for (int k = 8; k >= 1; k--) begin
            cand = ptr + 3'(k);
            if (req[cand]) pick = cand;
        end
    end

    // Arbitration FSM; every output is a register so req never reaches gnt
    // combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd7;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= 3'd7;
            gnt_vld  <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && (req != 8'h00)) begin
                        state    <= BUSY;
                        ptr      <= pick;
                        gnt_idx  <= pick;
                        gnt_vld  <= 1'b1;
                        gnt      <= 8'b1 << pick;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!req[gnt_idx]) begin
                        // Holder let go; one IDLE cycle gives bus turnaround.
                        state   <= IDLE;
                        gnt_vld <= 1'b0;
                        gnt     <= '0;
                    end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
                        // Hold limit reached; ptr already points at the holder,
                        // so every other requester goes first next time.
                        state   <= IDLE;
                        gnt_vld <= 1'b0;
                        gnt     <= '0;
                        preempt <= 1'b1;
                    end else if (hold_cnt != {CNT_W{1'b1}}) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_vld <= 1'b0;
                    gnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb8_dec.sv
// Directed bench for rr_arb8_dec: one instance with unlimited hold and one
// with MAX_HOLD=4 share the same stimulus.
module tb_rr_arb8_dec;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;

    logic [7:0] g0, g4;
    logic [2:0] i0, i4;
    logic       v0, v4, p0, p4;

    int n_cmp;
    int n_bad;

    rr_arb8_dec #(.MAX_HOLD(0), .CNT_W(5)) dut0 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(g0), .gnt_idx(i0), .gnt_vld(v0), .preempt(p0)
    );

    rr_arb8_dec #(.MAX_HOLD(4), .CNT_W(5)) dut4 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(g4), .gnt_idx(i4), .gnt_vld(v4), .preempt(p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        en  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        step();
        step();
        chk("rst_gnt", 32'(g0), 32'h00);
        chk("rst_idx", 32'(i0), 32'd7);
        chk("rst_vld", 32'(v0), 32'd0);
        chk("rst_pre", 32'(p4), 32'd0);
        rst = 1'b0;

        // 1: first priority to requester 0, then wrap to 7 after a gap
        en  = 1'b1;
        req = 8'h81;
        step();
        chk("t1_gnt0", 32'(g0), 32'h01);
        chk("t1_idx0", 32'(i0), 32'd0);
        req = 8'h80;
        step();
        chk("t1_gap", 32'(g0), 32'h00);
        chk("t1_gap_idx", 32'(i0), 32'd0);
        step();
        chk("t1_gnt7", 32'(g0), 32'h80);
        chk("t1_idx7", 32'(i0), 32'd7);

        // 2: all request, each holder releases after 3 BUSY cycles
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            int k;
            k = n % 8;
            step();
            chk($sformatf("t2_gnt%0d", n), 32'(g0), 32'(8'h01 << k));
            step();
            chk($sformatf("t2_hold%0d", n), 32'(g0), 32'(8'h01 << k));
            step();
            chk($sformatf("t2_hold%0d_b", n), 32'(g4), 32'(8'h01 << k));
            req[k] = 1'b0;
            step();
            chk($sformatf("t2_gap%0d", n), 32'(g0), 32'h00);
            req[k] = 1'b1;
        end

        // 3: hold limit on a single requester
        do_reset();
        en  = 1'b1;
        req = 8'h04;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("t3_gnt_c%0d", c), 32'(g4), 32'h04);
            chk($sformatf("t3_pre_c%0d", c), 32'(p4), 32'd0);
        end
        step();
        chk("t3_pre", 32'(p4), 32'd1);
        chk("t3_pre_gnt", 32'(g4), 32'h00);
        chk("t3_pre_vld", 32'(v4), 32'd0);
        chk("t3_unlim", 32'(g0), 32'h04);
        step();
        chk("t3_regnt", 32'(g4), 32'h04);
        chk("t3_pre_end", 32'(p4), 32'd0);

        // 4: two holders alternate under the limit
        do_reset();
        en  = 1'b1;
        req = 8'h14;
        for (int r = 0; r < 2; r++) begin
            logic [7:0] exp_g;
            exp_g = (r == 0) ? 8'h04 : 8'h10;
            for (int c = 0; c < 4; c++) begin
                step();
                chk($sformatf("t4_r%0d_c%0d", r, c), 32'(g4), 32'(exp_g));
            end
            step();
            chk($sformatf("t4_pre%0d", r), 32'(p4), 32'd1);
            chk($sformatf("t4_gap%0d", r), 32'(g4), 32'h00);
        end
        step();
        chk("t4_back2", 32'(g4), 32'h04);
        chk("t4_idx2", 32'(i4), 32'd2);

        // 5: en gates new grants only
        do_reset();
        en  = 1'b0;
        req = 8'h10;
        step();
        step();
        chk("t5_blk_gnt", 32'(g0), 32'h00);
        chk("t5_blk_vld", 32'(v0), 32'd0);
        en = 1'b1;
        step();
        chk("t5_gnt", 32'(g0), 32'h10);
        en = 1'b0;
        step();
        chk("t5_keep", 32'(g0), 32'h10);
        step();
        chk("t5_keep2", 32'(g0), 32'h10);
        chk("t5_idx", 32'(i0), 32'd4);

        // 6: reset mid-grant
        do_reset();
        en  = 1'b1;
        req = 8'h20;
        step();
        chk("t6_gnt", 32'(g0), 32'h20);
        rst = 1'b1;
        step();
        chk("t6_rst_gnt", 32'(g0), 32'h00);
        chk("t6_rst_idx", 32'(i0), 32'd7);
        chk("t6_rst_vld", 32'(v0), 32'd0);
        rst = 1'b0;
        step();
        chk("t6_regnt", 32'(g0), 32'h20);
        chk("t6_regnt_idx", 32'(i0), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
